// File: rtl/bp_cfg_io_endpoint.sv
// rtl/bp_cfg_io_endpoint.sv - IO endpoint: local config registers (freeze) plus in-order forwarding to memory
// Every accepted command gets exactly one response, returned in command order.
module bp_cfg_io_endpoint #(
  parameter int paddr_width_p        = 40,
  parameter int cce_block_width_p    = 64,
  parameter int lce_id_width_p       = 4,
  parameter int lce_assoc_p          = 8,
  parameter int dword_width_p        = 64,
  parameter int io_noc_max_credits_p = 4,
  parameter int order_els_p          = io_noc_max_credits_p,
  parameter int cfg_addr_width_p     = 16,
  parameter logic [paddr_width_p-cfg_addr_width_p-1:0] cfg_dev_gp = 'h000200,
  parameter logic [cfg_addr_width_p-1:0] bp_cfg_reg_freeze_gp = 'h0008,
  localparam int msg_type_width_lp    = 4,
  localparam int size_width_lp        = 3,
  localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_assoc_p),
  localparam int cce_mem_msg_width_lp = msg_type_width_lp + paddr_width_p + size_width_lp
                                        + payload_width_lp + cce_block_width_p
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [cce_mem_msg_width_lp-1:0] io_cmd_i,
  input  logic                            io_cmd_v_i,
  output logic                            io_cmd_yumi_o,
  output logic [cce_mem_msg_width_lp-1:0] io_resp_o,
  output logic                            io_resp_v_o,
  input  logic                            io_resp_ready_i,
  output logic [cce_mem_msg_width_lp-1:0] mem_cmd_o,
  output logic                            mem_cmd_v_o,
  input  logic                            mem_cmd_ready_i,
  input  logic [cce_mem_msg_width_lp-1:0] mem_resp_i,
  input  logic                            mem_resp_v_i,
  output logic                            mem_resp_yumi_o,
  output logic                            freeze_o
);

  // Message layout, LSB first: msg_type, addr, size, payload, data
  localparam int addr_lsb_lp    = msg_type_width_lp;
  localparam int size_lsb_lp    = addr_lsb_lp + paddr_width_p;
  localparam int payload_lsb_lp = size_lsb_lp + size_width_lp;
  localparam int data_lsb_lp    = payload_lsb_lp + payload_width_lp;

  localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_rd = 4'b0010;
  localparam logic [msg_type_width_lp-1:0] e_cce_mem_uc_wr = 4'b0011;

  localparam int ptr_width_lp = (order_els_p > 1) ? $clog2(order_els_p) : 1;
  localparam int cnt_width_lp = $clog2(order_els_p + 1);

  logic [msg_type_width_lp-1:0]    cmd_type;
  logic [paddr_width_p-1:0]        cmd_addr;
  logic [cfg_addr_width_p-1:0]     cfg_idx;
  logic                            is_cfg;
  logic                            is_freeze;

  logic                            freeze_r;
  logic                            reset_r;
  logic                            in_reset;
  logic                            local_v_r;
  logic [cce_mem_msg_width_lp-1:0] slot_r;
  logic [dword_width_p-1:0]        cfg_rdata;

  logic [order_els_p-1:0]          order_r;
  logic [ptr_width_lp-1:0]         rd_ptr_r;
  logic [ptr_width_lp-1:0]         wr_ptr_r;
  logic [cnt_width_lp-1:0]         count_r;
  logic                            full;
  logic                            empty;
  logic                            head_local;

  logic                            cfg_accept;
  logic                            mem_accept;
  logic                            push;
  logic                            pop;
  logic                            resp_fire;

  function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(order_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign cmd_type  = io_cmd_i[msg_type_width_lp-1:0];
  assign cmd_addr  = io_cmd_i[addr_lsb_lp +: paddr_width_p];
  assign cfg_idx   = cmd_addr[cfg_addr_width_p-1:0];
  assign is_cfg    = (cmd_addr[paddr_width_p-1:cfg_addr_width_p] == cfg_dev_gp);
  assign is_freeze = (cfg_idx == bp_cfg_reg_freeze_gp);

  // Hold off the command side through the cycle following reset
  assign in_reset  = reset_i | reset_r;

  assign full       = (count_r == cnt_width_lp'(order_els_p));
  assign empty      = (count_r == '0);
  assign head_local = order_r[rd_ptr_r];

  assign cfg_accept    = io_cmd_v_i & is_cfg & ~full & ~local_v_r & ~in_reset;
  assign mem_cmd_v_o   = io_cmd_v_i & ~is_cfg & ~full & ~in_reset;
  assign mem_cmd_o     = io_cmd_i;
  assign mem_accept    = mem_cmd_v_o & mem_cmd_ready_i;
  assign io_cmd_yumi_o = cfg_accept | mem_accept;
  assign push          = io_cmd_yumi_o;

  assign io_resp_o       = head_local ? slot_r : mem_resp_i;
  assign io_resp_v_o     = ~empty & ~in_reset & (head_local ? local_v_r : mem_resp_v_i);
  assign resp_fire       = io_resp_v_o & io_resp_ready_i;
  assign mem_resp_yumi_o = resp_fire & ~head_local;
  assign pop             = resp_fire;

  assign freeze_o = freeze_r;

  always_comb begin
    cfg_rdata = '0;
    if (cmd_type == e_cce_mem_uc_rd && is_freeze) cfg_rdata[0] = freeze_r;
  end

  always_ff @(posedge clk_i) begin
    reset_r <= reset_i;
    if (reset_i) begin
      freeze_r  <= 1'b1;
      local_v_r <= 1'b0;
      rd_ptr_r  <= '0;
      wr_ptr_r  <= '0;
      count_r   <= '0;
    end else begin
      if (push) begin
        order_r[wr_ptr_r] <= cfg_accept;
        wr_ptr_r          <= ptr_inc(wr_ptr_r);
      end
      if (pop) rd_ptr_r <= ptr_inc(rd_ptr_r);
      count_r <= count_r + cnt_width_lp'(push) - cnt_width_lp'(pop);

      // Accept needs the slot empty, so a clear and a load never collide
      if (cfg_accept) begin
        local_v_r <= 1'b1;
        slot_r    <= {cce_block_width_p'(cfg_rdata), io_cmd_i[data_lsb_lp-1:0]};
        if (cmd_type == e_cce_mem_uc_wr && is_freeze) freeze_r <= io_cmd_i[data_lsb_lp];
      end else if (resp_fire & head_local) begin
        local_v_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bp_cfg_io_endpoint.sv
// tb/tb_bp_cfg_io_endpoint.sv - directed self-checking bench for bp_cfg_io_endpoint
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_bp_cfg_io_endpoint;

  localparam int MSG_W     = 118;
  localparam int ORDER_ELS = 4;
  localparam logic [3:0]  UC_RD      = 4'b0010;
  localparam logic [3:0]  UC_WR      = 4'b0011;
  localparam logic [23:0] CFG_DEV    = 24'h000200;
  localparam logic [15:0] FREEZE_IDX = 16'h0008;
  localparam logic [15:0] OTHER_IDX  = 16'h0010;
  localparam logic [2:0]  SZ         = 3'd3;
  localparam logic [6:0]  PL         = 7'h35;

  logic             clk = 1'b0;
  logic             reset;
  logic [MSG_W-1:0] io_cmd, io_resp, mem_cmd, mem_resp;
  logic             io_cmd_v, io_cmd_yumi, io_resp_v, io_resp_ready;
  logic             mem_cmd_v, mem_cmd_ready, mem_resp_v, mem_resp_yumi, freeze;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bp_cfg_io_endpoint #(
    .paddr_width_p(40), .cce_block_width_p(64), .lce_id_width_p(4), .lce_assoc_p(8),
    .dword_width_p(64), .io_noc_max_credits_p(ORDER_ELS), .order_els_p(ORDER_ELS),
    .cfg_addr_width_p(16), .cfg_dev_gp(CFG_DEV), .bp_cfg_reg_freeze_gp(FREEZE_IDX)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .io_cmd_i(io_cmd), .io_cmd_v_i(io_cmd_v), .io_cmd_yumi_o(io_cmd_yumi),
    .io_resp_o(io_resp), .io_resp_v_o(io_resp_v), .io_resp_ready_i(io_resp_ready),
    .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
    .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v), .mem_resp_yumi_o(mem_resp_yumi),
    .freeze_o(freeze)
  );

  function automatic logic [MSG_W-1:0] make_msg(input logic [3:0] t, input logic [39:0] a,
                                                input logic [2:0] s, input logic [6:0] p,
                                                input logic [63:0] d);
    return {d, p, s, a, t};
  endfunction

  // Issue one config command into an idle endpoint and capture its response
  task automatic cfg_txn(input logic [3:0] t, input logic [15:0] idx, input logic [63:0] d,
                         output logic [MSG_W-1:0] resp, output logic got);
    @(negedge clk);
    io_cmd = make_msg(t, {CFG_DEV, idx}, SZ, PL, d);
    io_cmd_v = 1'b1; io_resp_ready = 1'b1; mem_resp_v = 1'b0;
    @(negedge clk);
    io_cmd_v = 1'b0;
    got = 1'b0; resp = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (io_resp_v === 1'b1) begin resp = io_resp; got = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    io_cmd = make_msg(UC_WR, 40'h80000000, SZ, PL, 64'h1); io_cmd_v = 1'b1; mem_cmd_ready = 1'b1;
    mem_resp = make_msg(UC_WR, 40'h80000000, SZ, PL, 64'h0); mem_resp_v = 1'b1; io_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL reset_freeze: got %b want 1", freeze); end
    n_checks++; if (io_cmd_yumi !== 1'b0) begin n_fail++; $display("FAIL reset_yumi: got %b want 0", io_cmd_yumi); end
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL reset_resp_v: got %b want 0", io_resp_v); end
    n_checks++; if (mem_cmd_v !== 1'b0) begin n_fail++; $display("FAIL reset_mem_cmd_v: got %b want 0", mem_cmd_v); end
    n_checks++; if (mem_resp_yumi !== 1'b0) begin n_fail++; $display("FAIL reset_mem_resp_yumi: got %b want 0", mem_resp_yumi); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b0) begin n_fail++; $display("FAIL post_reset_yumi: got %b want 0", io_cmd_yumi); end
    n_checks++; if (mem_cmd_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_mem_cmd_v: got %b want 0", mem_cmd_v); end
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL post_reset_resp_v: got %b want 0", io_resp_v); end
    io_cmd_v = 1'b0; mem_resp_v = 1'b0;
  endtask

  task automatic test_freeze_release();
    logic [39:0] a;
    a = {CFG_DEV, FREEZE_IDX};
    @(negedge clk);
    io_cmd = make_msg(UC_WR, a, SZ, PL, 64'hFFFF_FFFF_FFFF_FFFE); io_cmd_v = 1'b1; io_resp_ready = 1'b1;
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b1) begin n_fail++; $display("FAIL rel_yumi: got %b want 1", io_cmd_yumi); end
    n_checks++; if (mem_cmd_v !== 1'b0) begin n_fail++; $display("FAIL rel_mem_cmd_v: got %b want 0", mem_cmd_v); end
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL rel_resp_early: got %b want 0", io_resp_v); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL rel_freeze_before: got %b want 1", freeze); end
    @(negedge clk);
    io_cmd_v = 1'b0;
    #1;
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL rel_freeze_after: got %b want 0", freeze); end
    n_checks++; if (io_resp_v !== 1'b1) begin n_fail++; $display("FAIL rel_resp_v: got %b want 1", io_resp_v); end
    n_checks++; if (io_resp !== make_msg(UC_WR, a, SZ, PL, 64'h0)) begin n_fail++;
      $display("FAIL rel_resp: got %h want %h", io_resp, make_msg(UC_WR, a, SZ, PL, 64'h0)); end
    @(negedge clk);
    #1;
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL rel_resp_done: got %b want 0", io_resp_v); end
  endtask

  task automatic test_freeze_readback();
    logic [MSG_W-1:0] r, e;
    logic g;
    cfg_txn(UC_RD, FREEZE_IDX, 64'hDEAD_BEEF, r, g);
    e = make_msg(UC_RD, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    n_checks++; if (g !== 1'b1 || r !== e) begin n_fail++; $display("FAIL rd_freeze0: got %b/%h want 1/%h", g, r, e); end
    cfg_txn(UC_WR, FREEZE_IDX, 64'h1, r, g);
    e = make_msg(UC_WR, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    n_checks++; if (g !== 1'b1 || r !== e) begin n_fail++; $display("FAIL wr_freeze1_resp: got %b/%h want 1/%h", g, r, e); end
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL wr_freeze1: got %b want 1", freeze); end
    cfg_txn(UC_RD, FREEZE_IDX, 64'h0, r, g);
    e = make_msg(UC_RD, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h1);
    n_checks++; if (g !== 1'b1 || r !== e) begin n_fail++; $display("FAIL rd_freeze1: got %b/%h want 1/%h", g, r, e); end
    cfg_txn(UC_WR, OTHER_IDX, 64'h0, r, g);
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL other_wr_ignored: got %b want 1", freeze); end
    cfg_txn(UC_RD, OTHER_IDX, 64'h5, r, g);
    e = make_msg(UC_RD, {CFG_DEV, OTHER_IDX}, SZ, PL, 64'h0);
    n_checks++; if (g !== 1'b1 || r !== e) begin n_fail++; $display("FAIL other_rd_zero: got %b/%h want 1/%h", g, r, e); end
  endtask

  task automatic test_mem_passthrough();
    logic [MSG_W-1:0] c, m;
    c = make_msg(UC_WR, 40'h80000000, SZ, PL, 64'h0123_4567_89AB_CDEF);
    m = make_msg(UC_WR, 40'h80000000, SZ, PL, 64'h0000_0000_0000_CAFE);
    @(negedge clk);
    io_cmd = c; io_cmd_v = 1'b1; mem_cmd_ready = 1'b0; io_resp_ready = 1'b1;
    #1;
    n_checks++; if (mem_cmd_v !== 1'b1) begin n_fail++; $display("FAIL pt_mem_cmd_v: got %b want 1", mem_cmd_v); end
    n_checks++; if (io_cmd_yumi !== 1'b0) begin n_fail++; $display("FAIL pt_yumi_not_ready: got %b want 0", io_cmd_yumi); end
    mem_cmd_ready = 1'b1;
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b1) begin n_fail++; $display("FAIL pt_yumi: got %b want 1", io_cmd_yumi); end
    n_checks++; if (mem_cmd !== c) begin n_fail++; $display("FAIL pt_mem_cmd: got %h want %h", mem_cmd, c); end
    @(negedge clk);
    io_cmd_v = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL pt_resp_early: got %b want 0", io_resp_v); end
    @(negedge clk);
    mem_resp = m; mem_resp_v = 1'b1; io_resp_ready = 1'b0;
    #1;
    n_checks++; if (io_resp_v !== 1'b1 || mem_resp_yumi !== 1'b0) begin n_fail++;
      $display("FAIL pt_hold: got v=%b yumi=%b want v=1 yumi=0", io_resp_v, mem_resp_yumi); end
    io_resp_ready = 1'b1;
    #1;
    n_checks++; if (io_resp !== m) begin n_fail++; $display("FAIL pt_resp: got %h want %h", io_resp, m); end
    n_checks++; if (mem_resp_yumi !== 1'b1) begin n_fail++; $display("FAIL pt_mem_yumi: got %b want 1", mem_resp_yumi); end
    @(negedge clk);
    mem_resp_v = 1'b0;
    #1;
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL pt_resp_done: got %b want 0", io_resp_v); end
  endtask

  task automatic test_ordering();
    logic [MSG_W-1:0] m, e;
    logic held;
    m = make_msg(UC_RD, 40'h80000040, SZ, PL, 64'h1111_2222_3333_4444);
    e = make_msg(UC_WR, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    @(negedge clk);
    io_cmd = make_msg(UC_RD, 40'h80000040, SZ, PL, 64'h0); io_cmd_v = 1'b1; mem_cmd_ready = 1'b1;
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b1) begin n_fail++; $display("FAIL ord_mem_yumi: got %b want 1", io_cmd_yumi); end
    @(negedge clk);
    io_cmd = make_msg(UC_WR, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b1) begin n_fail++; $display("FAIL ord_cfg_yumi: got %b want 1", io_cmd_yumi); end
    @(negedge clk);
    io_cmd_v = 1'b0; io_resp_ready = 1'b1;
    held = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (io_resp_v !== 1'b0) held = 1'b0;
      @(negedge clk);
    end
    n_checks++; if (held !== 1'b1) begin n_fail++; $display("FAIL ord_cfg_withheld: got %b want 1", held); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL ord_freeze: got %b want 0", freeze); end
    mem_resp = m; mem_resp_v = 1'b1;
    #1;
    n_checks++; if (io_resp_v !== 1'b1 || io_resp !== m) begin n_fail++;
      $display("FAIL ord_mem_first: got %b/%h want 1/%h", io_resp_v, io_resp, m); end
    n_checks++; if (mem_resp_yumi !== 1'b1) begin n_fail++; $display("FAIL ord_mem_yumi_resp: got %b want 1", mem_resp_yumi); end
    @(negedge clk);
    #1;
    n_checks++; if (io_resp_v !== 1'b1 || io_resp !== e) begin n_fail++;
      $display("FAIL ord_cfg_next: got %b/%h want 1/%h", io_resp_v, io_resp, e); end
    n_checks++; if (mem_resp_yumi !== 1'b0) begin n_fail++; $display("FAIL ord_stray_held: got %b want 0", mem_resp_yumi); end
    @(negedge clk);
    mem_resp_v = 1'b0;
    #1;
    n_checks++; if (io_resp_v !== 1'b0) begin n_fail++; $display("FAIL ord_done: got %b want 0", io_resp_v); end
  endtask

  task automatic test_backpressure();
    int accepted, drained;
    @(negedge clk);
    io_cmd = make_msg(UC_WR, 40'h80000100, SZ, PL, 64'h7); io_cmd_v = 1'b1;
    mem_cmd_ready = 1'b1; io_resp_ready = 1'b1; mem_resp_v = 1'b0;
    mem_resp = make_msg(UC_WR, 40'h80000100, SZ, PL, 64'h0);
    accepted = 0;
    for (int i = 0; i < ORDER_ELS; i++) begin
      #1;
      if (io_cmd_yumi === 1'b1) accepted++;
      @(negedge clk);
    end
    n_checks++; if (accepted != ORDER_ELS) begin n_fail++; $display("FAIL bp_fill: got %0d want %0d", accepted, ORDER_ELS); end
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b0 || mem_cmd_v !== 1'b0) begin n_fail++;
      $display("FAIL bp_full_block: got yumi=%b v=%b want 0/0", io_cmd_yumi, mem_cmd_v); end
    @(negedge clk);
    mem_resp_v = 1'b1;
    #1;
    n_checks++; if (mem_resp_yumi !== 1'b1) begin n_fail++; $display("FAIL bp_pop: got %b want 1", mem_resp_yumi); end
    n_checks++; if (io_cmd_yumi !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_push: got %b want 0", io_cmd_yumi); end
    @(negedge clk);
    mem_resp_v = 1'b0;
    #1;
    n_checks++; if (io_cmd_yumi !== 1'b1) begin n_fail++; $display("FAIL bp_reopen: got %b want 1", io_cmd_yumi); end
    @(negedge clk);
    io_cmd_v = 1'b0;
    drained = 0;
    for (int i = 0; i < ORDER_ELS; i++) begin
      mem_resp_v = 1'b1;
      #1;
      if (mem_resp_yumi === 1'b1) drained++;
      @(negedge clk);
    end
    mem_resp_v = 1'b0;
    #1;
    n_checks++; if (drained != ORDER_ELS || io_resp_v !== 1'b0) begin n_fail++;
      $display("FAIL bp_drain: got %0d/%b want %0d/0", drained, io_resp_v, ORDER_ELS); end
  endtask

  task automatic test_reset_mid();
    logic [MSG_W-1:0] r, e;
    logic g, quiet;
    @(negedge clk);
    io_cmd = make_msg(UC_RD, 40'h80000200, SZ, PL, 64'h0); io_cmd_v = 1'b1;
    mem_cmd_ready = 1'b1; mem_resp_v = 1'b0; io_resp_ready = 1'b1;
    @(negedge clk);
    io_cmd = make_msg(UC_RD, 40'h80000208, SZ, PL, 64'h0);
    @(negedge clk);
    io_cmd = make_msg(UC_WR, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    @(negedge clk);
    io_cmd_v = 1'b0;
    #1;
    n_checks++; if (freeze !== 1'b0 || io_resp_v !== 1'b0) begin n_fail++;
      $display("FAIL mid_pending: got freeze=%b v=%b want 0/0", freeze, io_resp_v); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (freeze !== 1'b1) begin n_fail++; $display("FAIL mid_freeze: got %b want 1", freeze); end
    @(negedge clk);
    reset = 1'b0;
    mem_resp = make_msg(UC_RD, 40'h80000200, SZ, PL, 64'h9); mem_resp_v = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (io_resp_v !== 1'b0 || mem_resp_yumi !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    mem_resp_v = 1'b0;
    n_checks++; if (quiet !== 1'b1) begin n_fail++; $display("FAIL mid_no_resp: got %b want 1", quiet); end
    cfg_txn(UC_WR, FREEZE_IDX, 64'h0, r, g);
    e = make_msg(UC_WR, {CFG_DEV, FREEZE_IDX}, SZ, PL, 64'h0);
    n_checks++; if (g !== 1'b1 || r !== e) begin n_fail++; $display("FAIL mid_new_cfg: got %b/%h want 1/%h", g, r, e); end
    n_checks++; if (freeze !== 1'b0) begin n_fail++; $display("FAIL mid_new_freeze: got %b want 0", freeze); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_freeze_release();
    test_freeze_readback();
    test_mem_passthrough();
    test_ordering();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
